// File: rtl/eight_to_three_pkg.sv
// Shared definitions for the 8-to-3 priority encoder and its 16-line cascade.
// Contents: FSM state encoding, line/code widths, and a one-hot helper used
// to build the clear mask for the serviced pending bit.
package eight_to_three_pkg;

    localparam int unsigned NLINES = 8;
    localparam int unsigned CODEW  = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    function automatic logic [NLINES-1:0] onehot(input logic [CODEW-1:0] idx);
        logic [NLINES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/eight_to_three_encoder_prio8.sv
// prio8: combinational 8-bit priority function.
// Ports:
//   P          in  8  pending bits, active-high
//   HIGH_FIRST in  1  1 = highest set index wins, 0 = lowest set index wins
//   idx        out 3  index of the winning bit (0 when P is empty)
module prio8
    import eight_to_three_pkg::*;
(
    input  logic [NLINES-1:0] P,
    input  logic              HIGH_FIRST,
    output logic [CODEW-1:0]  idx
);

    // Both scans run upward through their priority order so the last hit
    // (the highest-priority set bit) is the one that sticks.
    always_comb begin
        idx = '0;
        if (HIGH_FIRST) begin
            for (int unsigned i = 0; i < NLINES; i++) begin
                if (P[i]) idx = CODEW'(i);
            end
        end else begin
            for (int unsigned i = 0; i < NLINES; i++) begin
                if (P[NLINES-1-i]) idx = CODEW'(NLINES-1-i);
            end
        end
    end

endmodule

// File: rtl/eight_to_three_encoder.sv
// eight_to_three_encoder: sequential 74148-style 8-to-3 priority encoder.
// Active-low request strobes are captured into a pending register. The
// highest-priority pending line is presented on A with a VALID/ACK
// handshake, and the serviced bit is cleared on ACK.
// Ports:
//   CLK   in  1  system clock, rising edge
//   RSTN  in  1  synchronous active-low reset
//   IN    in  8  request lines, active-low
//   EIN   in  1  enable, active-low; 1 blocks captures and new grants
//   A     out 3  granted index
//   VALID out 1  A holds a grant awaiting ACK
//   ACK   in  1  consumer accepts the grant (only while VALID=1)
//   GSN   out 1  group select, active-low (~VALID)
//   EON   out 1  enable output, active-low; 0 when enabled, empty and idle
module eight_to_three_encoder
    import eight_to_three_pkg::*;
#(
    parameter logic HIGH_FIRST = 1'b1
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [7:0] IN,
    input  logic       EIN,
    output logic [2:0] A,
    output logic       VALID,
    input  logic       ACK,
    output logic       GSN,
    output logic       EON
);

    state_e            state_q, state_d;
    logic [NLINES-1:0] p_q, p_d;
    logic [CODEW-1:0]  a_q, a_d;
    logic              valid_q, valid_d;

    logic [CODEW-1:0]  prio_idx;
    logic [NLINES-1:0] clr;
    logic              ack_acc;

    prio8 u_prio8 (
        .P          (p_q),
        .HIGH_FIRST (HIGH_FIRST),
        .idx        (prio_idx)
    );

    always_comb begin
        ack_acc = (state_q == ST_PRESENT) && ACK;
        clr     = ack_acc ? onehot(a_q) : '0;

        // Clear first, then OR in new requests so a request on the bit
        // being serviced re-arms it. Clearing still happens with EIN=1
        // because a grant in flight must complete.
        p_d = p_q & ~clr;
        if (!EIN) p_d = p_d | ~IN;

        state_d = state_q;
        a_d     = a_q;
        valid_d = valid_q;

        if (state_q == ST_IDLE) begin
            // Grant decision uses registered P, never this cycle's capture.
            if (!EIN && (p_q != '0)) begin
                a_d     = prio_idx;
                valid_d = 1'b1;
                state_d = ST_PRESENT;
            end
        end else begin
            if (ACK) begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            a_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            a_q     <= a_d;
            valid_q <= valid_d;
        end
    end

    assign A     = a_q;
    assign VALID = valid_q;
    assign GSN   = ~valid_q;
    // RSTN keeps EON deasserted while reset is held, so a cascaded
    // neighbour does not see this stage as an empty, enabled encoder.
    assign EON   = ~(RSTN && !EIN && (p_q == '0) && (state_q == ST_IDLE));

endmodule

// File: tb/tb_eight_to_three_encoder.sv
module tb_eight_to_three_encoder;

    logic       CLK;
    logic [7:0] in_r;
    logic       ein_r, ack_r, rstn_r;

    logic [2:0] a_o     [2];
    logic       valid_o [2];
    logic       gsn_o   [2];
    logic       eon_o   [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one per instance (0: HIGH_FIRST=1, 1: HIGH_FIRST=0)
    int m_p [2];
    int m_a [2];
    bit m_v [2];
    bit hf  [2] = '{1'b1, 1'b0};

    eight_to_three_encoder #(.HIGH_FIRST(1'b1)) u_hi (
        .CLK(CLK), .RSTN(rstn_r), .IN(in_r), .EIN(ein_r),
        .A(a_o[0]), .VALID(valid_o[0]), .ACK(ack_r), .GSN(gsn_o[0]), .EON(eon_o[0])
    );

    eight_to_three_encoder #(.HIGH_FIRST(1'b0)) u_lo (
        .CLK(CLK), .RSTN(rstn_r), .IN(in_r), .EIN(ein_r),
        .A(a_o[1]), .VALID(valid_o[1]), .ACK(ack_r), .GSN(gsn_o[1]), .EON(eon_o[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Position of the most significant set bit of a positive value.
    function automatic int msb(input int v);
        int n;
        n = 0;
        while (v > 1) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    function automatic int pick(input int p, input bit high_first);
        if (high_first) return msb(p);
        return msb(p & (-p));
    endfunction

    task automatic model_update(input int d);
        int clr, np;
        if (!rstn_r) begin
            m_p[d] = 0;
            m_a[d] = 0;
            m_v[d] = 1'b0;
        end else begin
            clr = (m_v[d] && ack_r) ? (1 << m_a[d]) : 0;
            np  = m_p[d] & ~clr & 255;
            if (!ein_r) np = np | (255 - int'(in_r));
            if (!m_v[d]) begin
                if (!ein_r && m_p[d] != 0) begin
                    m_a[d] = pick(m_p[d], hf[d]);
                    m_v[d] = 1'b1;
                end
            end else if (ack_r) begin
                m_v[d] = 1'b0;
            end
            m_p[d] = np;
        end
    endtask

    task automatic check_all(input int d);
        logic exp_eon;
        exp_eon = (rstn_r && !ein_r && m_p[d] == 0 && !m_v[d]) ? 1'b0 : 1'b1;
        check_eq($sformatf("d%0d_A", d),     {5'b0, a_o[d]},     m_a[d][7:0]);
        check_eq($sformatf("d%0d_VALID", d), {7'b0, valid_o[d]}, {7'b0, m_v[d]});
        check_eq($sformatf("d%0d_GSN", d),   {7'b0, gsn_o[d]},   {7'b0, ~m_v[d]});
        check_eq($sformatf("d%0d_EON", d),   {7'b0, eon_o[d]},   {7'b0, exp_eon});
    endtask

    // Apply inputs, take one rising edge, then compare both DUTs at the falling edge.
    task automatic step(input logic [7:0] i, input logic e, input logic k, input logic r);
        in_r   = i;
        ein_r  = e;
        ack_r  = k;
        rstn_r = r;
        @(posedge CLK);
        model_update(0);
        model_update(1);
        @(negedge CLK);
        check_all(0);
        check_all(1);
    endtask

    task automatic check_both(input string tag, input logic [2:0] a_exp, input logic v_exp);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s_d%0d_VALID", tag, d), {7'b0, valid_o[d]}, {7'b0, v_exp});
            if (v_exp) check_eq($sformatf("%s_d%0d_A", tag, d), {5'b0, a_o[d]}, {5'b0, a_exp});
        end
    endtask

    int seq [2][$];
    int exp_seq [2][4] = '{'{7, 5, 2, 0}, '{0, 2, 5, 7}};

    initial begin
        // Reset then idle
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        check_eq("rst_A",   {5'b0, a_o[0]},     8'd0);
        check_eq("rst_EON", {7'b0, eon_o[0]},   8'd1);
        check_eq("rst_GSN", {7'b0, gsn_o[0]},   8'd1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        check_eq("idle_EON", {7'b0, eon_o[0]},  8'd0);
        check_both("idle", 3'd0, 1'b0);

        // Single one-cycle request on line 3
        step(8'hF7, 1'b0, 1'b1, 1'b1);
        step(8'hFF, 1'b0, 1'b1, 1'b1);
        check_both("line3", 3'd3, 1'b1);
        check_eq("line3_GSN", {7'b0, gsn_o[0]}, 8'd0);
        step(8'hFF, 1'b0, 1'b1, 1'b1);
        check_both("line3_clr", 3'd0, 1'b0);
        check_eq("line3_EON", {7'b0, eon_o[0]}, 8'd0);

        // Priority order from a single pulse on lines 0,2,5,7
        step(8'h5A, 1'b0, 1'b1, 1'b1);
        for (int s = 0; s < 9; s++) begin
            step(8'hFF, 1'b0, 1'b1, 1'b1);
            for (int d = 0; d < 2; d++)
                if (valid_o[d] === 1'b1) seq[d].push_back(int'(a_o[d]));
        end
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("prio_d%0d_count", d), 8'(seq[d].size()), 8'd4);
            for (int g = 0; g < 4 && g < seq[d].size(); g++)
                check_eq($sformatf("prio_d%0d_g%0d", d, g), 8'(seq[d][g]), 8'(exp_seq[d][g]));
        end

        // Stall: line 6 held without ACK while line 7 arrives
        step(8'hBF, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        for (int s = 0; s < 10; s++) begin
            step((s == 3) ? 8'h7F : 8'hFF, 1'b0, 1'b0, 1'b1);
            check_both("stall", 3'd6, 1'b1);
        end
        step(8'hFF, 1'b0, 1'b1, 1'b1);
        check_both("stall_ack", 3'd0, 1'b0);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        check_both("stall_next", 3'd7, 1'b1);
        step(8'hFF, 1'b0, 1'b1, 1'b1);

        // Set-wins collision on line 4
        step(8'hEF, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        check_both("coll_grant", 3'd4, 1'b1);
        step(8'hEF, 1'b0, 1'b1, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        check_both("coll_regrant", 3'd4, 1'b1);
        step(8'hFF, 1'b0, 1'b1, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        check_both("coll_empty", 3'd0, 1'b0);

        // Enable blocks captures and grants
        for (int s = 0; s < 3; s++) begin
            step(8'h00, 1'b1, 1'b0, 1'b1);
            check_eq("ein_EON", {7'b0, eon_o[0]}, 8'd1);
            check_both("ein_nogrant", 3'd0, 1'b0);
        end
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        check_both("ein_p_held", 3'd0, 1'b0);

        // Grant in flight completes with EIN=1
        step(8'hFE, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        check_both("ein_present", 3'd0, 1'b1);
        step(8'hFF, 1'b1, 1'b1, 1'b1);
        check_both("ein_ack", 3'd0, 1'b0);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        check_both("ein_cleared", 3'd0, 1'b0);

        // Reset mid-handshake
        step(8'hDF, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        check_both("rst_mid_pre", 3'd5, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        check_both("rst_mid", 3'd0, 1'b0);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        check_both("rst_mid_empty", 3'd0, 1'b0);

        // Randomized traffic against the model
        for (int s = 0; s < 3000; s++) begin
            step(~(8'($urandom) & 8'($urandom) & 8'($urandom)),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
